// File: rtl/pipeline_hazard_ctrl.sv
// Decode-to-execute issue control: load-use stall, forwarding selects, branch hold/flush, stall counter.
// id_ready/flush are combinational; ex_valid and fwd selects register one edge after issue.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs2_en,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write_en,
  input  logic              id_mem_read_en,
  input  logic              id_branch_en,
  input  logic              br_resolved,
  input  logic              br_taken,
  output logic              ex_valid,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_ex_vld;
  logic              r_ex_wr;
  logic              r_ex_ld;
  logic [ADDR_W-1:0] r_ex_rd;
  logic              r_mem_vld;
  logic              r_mem_wr;
  logic              r_mem_ld;
  logic [ADDR_W-1:0] r_mem_rd;

  logic              r_ex_valid;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_ex_src;
  logic              w_mem_src;
  logic              w_ex_a;
  logic              w_ex_b;
  logic              w_mem_a;
  logic              w_mem_b;
  logic              w_load_use;
  logic              w_issue;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // Only a valid, register-writing entry with a non-zero rd can create a hazard.
  assign w_ex_src  = r_ex_vld & r_ex_wr & (r_ex_rd != '0);
  assign w_mem_src = r_mem_vld & r_mem_wr & (r_mem_rd != '0);

  assign w_ex_a  = w_ex_src & (r_ex_rd == id_rs1);
  assign w_ex_b  = w_ex_src & id_rs2_en & (r_ex_rd == id_rs2);
  assign w_mem_a = w_mem_src & (r_mem_rd == id_rs1);
  assign w_mem_b = w_mem_src & id_rs2_en & (r_mem_rd == id_rs2);

  assign w_load_use = r_ex_ld & (w_ex_a | w_ex_b);
  assign id_ready   = (r_state == RUN) & ~w_load_use;
  assign w_issue    = id_valid & id_ready;
  assign flush      = (r_state == BR_WAIT) & br_resolved & br_taken;

  // An issuing instruction never matches a load in EX, so an EX match here is always an ALU result.
  assign w_fwd_a = w_ex_a ? 2'b01 : (w_mem_a ? 2'b10 : 2'b00);
  assign w_fwd_b = w_ex_b ? 2'b01 : (w_mem_b ? 2'b10 : 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_issue && id_branch_en) w_state_nxt = BR_WAIT;
      BR_WAIT: if (br_resolved) w_state_nxt = br_taken ? FLUSH : RUN;
      FLUSH:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_vld  <= 1'b0;
      r_ex_wr   <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_ex_rd   <= '0;
      r_mem_vld <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_ld  <= 1'b0;
      r_mem_rd  <= '0;
    end else begin
      r_mem_vld <= r_ex_vld;
      r_mem_wr  <= r_ex_wr;
      r_mem_ld  <= r_ex_ld;
      r_mem_rd  <= r_ex_rd;
      r_ex_vld  <= w_issue;
      r_ex_wr   <= w_issue & id_reg_write_en;
      r_ex_ld   <= w_issue & id_mem_read_en;
      r_ex_rd   <= w_issue ? id_rd : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
    end else begin
      r_ex_valid <= w_issue;
      r_fwd_a    <= w_issue ? w_fwd_a : 2'b00;
      r_fwd_b    <= w_issue ? w_fwd_b : 2'b00;
      if (id_valid && !id_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign ex_valid    = r_ex_valid;
  assign fwd_a_sel   = r_fwd_a;
  assign fwd_b_sel   = r_fwd_b;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard/branch/reset cases then random traffic,
// checked against a cycle-level reference model through a scoreboard of EX-stage expectations.
module tb_pipeline_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic          id_ready;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          id_rs2_en;
  logic [4:0]    id_rd;
  logic          id_reg_write_en;
  logic          id_mem_read_en;
  logic          id_branch_en;
  logic          br_resolved;
  logic          br_taken;
  logic          ex_valid;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic          flush;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en), .id_rd(id_rd),
    .id_reg_write_en(id_reg_write_en), .id_mem_read_en(id_mem_read_en),
    .id_branch_en(id_branch_en), .br_resolved(br_resolved), .br_taken(br_taken),
    .ex_valid(ex_valid), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .flush(flush), .stall_count(stall_count)
  );

  typedef struct {bit vld; int a; int b;} exp_t;
  typedef struct {bit vld; int rd; bit wr; bit ld;} slot_t;
  typedef enum {M_RUN, M_WAIT, M_FLUSH} mode_t;

  exp_t  sb[$];
  int    n_chk = 0;
  int    n_fail = 0;

  // Reference model: older[0] = instruction issued one edge ago, older[1] = two edges ago.
  slot_t older[2];
  mode_t mode;
  int    cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit wrote(input int k, input int r);
    return older[k].vld && older[k].wr && (older[k].rd != 0) && (older[k].rd == r);
  endfunction

  task automatic model_reset();
    mode = M_RUN;
    cnt  = 0;
    for (int k = 0; k < 2; k++) older[k] = '{1'b0, 0, 1'b0, 1'b0};
  endtask

  // One clock cycle: drive at the negedge, check combinational outputs, predict, advance.
  task automatic cyc(input bit v, input int s1, input int s2, input bit s2e, input int d,
                     input bit w, input bit l, input bit b, input bit res, input bit tk);
    bit lu, rdy, fl, issue;
    int a, bb;
    id_valid = v; id_rs1 = s1[4:0]; id_rs2 = s2[4:0]; id_rs2_en = s2e; id_rd = d[4:0];
    id_reg_write_en = w; id_mem_read_en = l; id_branch_en = b;
    br_resolved = res; br_taken = tk;
    #2;
    lu    = older[0].ld && (wrote(0, s1) || (s2e && wrote(0, s2)));
    rdy   = (mode == M_RUN) && !lu;
    fl    = (mode == M_WAIT) && res && tk;
    issue = v && rdy;
    a     = wrote(0, s1) ? 1 : (wrote(1, s1) ? 2 : 0);
    bb    = !s2e ? 0 : (wrote(0, s2) ? 1 : (wrote(1, s2) ? 2 : 0));
    chk("id_ready", int'(id_ready), int'(rdy));
    chk("flush", int'(flush), int'(fl));
    chk("stall_count", int'(stall_count), cnt);
    sb.push_back('{issue, a, bb});
    if (v && !rdy && cnt < SAT) cnt++;
    case (mode)
      M_RUN:   if (issue && b) mode = M_WAIT;
      M_WAIT:  if (res) mode = tk ? M_FLUSH : M_RUN;
      default: mode = M_RUN;
    endcase
    older[1] = older[0];
    older[0] = issue ? '{1'b1, d, w, l} : '{1'b0, 0, 1'b0, 1'b0};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu(input int s1, input int s2, input bit s2e, input int d);
    cyc(1, s1, s2, s2e, d, 1, 0, 0, 0, 0);
  endtask
  task automatic load(input int s1, input int d);
    cyc(1, s1, 0, 0, d, 1, 1, 0, 0, 0);
  endtask
  task automatic branch(input int s1, input bit res, input bit tk);
    cyc(1, s1, 0, 1, 0, 0, 0, 1, res, tk);
  endtask
  task automatic hold(input bit res, input bit tk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, res, tk);
  endtask

  // Monitor: each cycle's EX-stage result is compared with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (sb.size() == 0) begin
          chk("ex_valid_idle", int'(ex_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("ex_valid", int'(ex_valid), int'(e.vld));
          if (e.vld) begin
            chk("fwd_a_sel", int'(fwd_a_sel), e.a);
            chk("fwd_b_sel", int'(fwd_b_sel), e.b);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs2_en = 0; id_rd = 0;
    id_reg_write_en = 0; id_mem_read_en = 0; id_branch_en = 0;
    br_resolved = 0; br_taken = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ex_valid", int'(ex_valid), 0);
    chk("rst_fwd_a", int'(fwd_a_sel), 0);
    chk("rst_fwd_b", int'(fwd_b_sel), 0);
    chk("rst_stall_count", int'(stall_count), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_id_ready", int'(id_ready), 1);
    rst = 1'b0;

    // Back-to-back ALU dependency: EX forward on rs1, then MEM forward on rs2.
    alu(1, 2, 1, 5);
    alu(5, 0, 0, 6);
    alu(0, 5, 1, 8);
    // Load-use on rs2: one stall cycle then issue with MEM forward.
    load(1, 7);
    alu(0, 7, 1, 9);
    alu(0, 7, 1, 9);
    chk("load_use_stall_count", int'(stall_count), 1);
    // x0 never stalls or forwards; disabled rs2 never stalls.
    load(0, 0);
    alu(0, 0, 0, 10);
    load(0, 3);
    alu(1, 3, 0, 11);
    // Not-taken branch resolved in the third held cycle.
    branch(0, 0, 0);
    hold(0, 0);
    hold(0, 0);
    hold(1, 0);
    alu(2, 3, 1, 12);
    // Taken branch: flush in the resolving cycle then one more hold.
    branch(0, 0, 0);
    hold(0, 0);
    hold(0, 0);
    hold(1, 1);
    hold(0, 0);
    alu(4, 5, 1, 13);
    // Resolution arriving alongside the branch in RUN is ignored.
    branch(0, 1, 1);
    hold(1, 0);
    // Branch that hits load-use: stall first, then the branch enters BR_WAIT.
    load(0, 4);
    branch(4, 0, 0);
    branch(4, 0, 0);
    hold(1, 1);
    hold(0, 0);

    // Reset while waiting on a branch with a taken resolution on the inputs.
    branch(0, 0, 0);
    hold(0, 0);
    id_valid = 1; br_resolved = 1; br_taken = 1;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_flush", int'(flush), 0);
    chk("midrst_ex_valid", int'(ex_valid), 0);
    chk("midrst_fwd_a", int'(fwd_a_sel), 0);
    chk("midrst_stall_count", int'(stall_count), 0);
    chk("midrst_id_ready", int'(id_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    hold(1, 1);
    alu(0, 0, 0, 1);

    // Counter saturation while held in BR_WAIT.
    branch(0, 0, 0);
    for (int i = 0; i < 20; i++) hold(0, 0);
    chk("stall_saturated", int'(stall_count), SAT);
    hold(1, 0);

    // Random traffic over a small register range to provoke overlapping hazards.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Issue controller between the decode stage and the execute stage of the 5-stage RISC-V pipeline. It accepts decoded instructions through a valid/ready handshake and tracks the destination registers of instructions in EX and MEM in a shadow pipeline. From those it generates load-use stalls, operand-forwarding selects and branch hold/flush sequencing. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- ADDR_W, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decoded instruction present at ID
- id_ready  out  1  combinational; instruction issues this cycle when id_valid & id_ready
- id_rs1, id_rs2  in  ADDR_W  source register addresses
- id_rs2_en  in  1  rs2 is a real operand
- id_rd  in  ADDR_W  destination register
- id_reg_write_en, id_mem_read_en, id_branch_en  in  1  decoded control flags
- br_resolved  in  1  EX-stage branch outcome valid (single-cycle pulse)
- br_taken  in  1  qualified by br_resolved
- ex_valid  out  1  registered; instruction (not a bubble) present in EX
- fwd_a_sel, fwd_b_sel  out  2  registered; 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 unused
- flush  out  1  combinational; kill IF/ID contents this cycle
- stall_count  out  CNT_W  saturating stall-cycle count

## Operation
Shadow pipeline:
- Two shadow stages, S_EX and S_MEM. Each holds {valid, rd, wr, load}.
- Every cycle S_MEM <= S_EX.
- On issue, S_EX <= {1, id_rd, id_reg_write_en, id_mem_read_en}. Otherwise S_EX <= bubble (valid=0).
- A shadow entry is a hazard source only when valid & wr & rd != 0.

Operand matching:
- rs1 is always checked. rs2 is checked only when id_rs2_en=1.

Load-use stall:
- Condition: S_EX is a hazard source with load=1, and its rd matches a checked operand.
- Effect: id_ready=0 for that cycle and a bubble enters EX.

Forwarding (computed at issue, registered with ex_valid):
- sel=01 if S_EX matches (non-load).
- Otherwise sel=10 if S_MEM matches.
- Otherwise sel=00.
- S_EX has priority over S_MEM.
- rd=0 never forwards.
- Unchecked rs2 gives fwd_b_sel=00.

Branch FSM, states RUN, BR_WAIT, FLUSH:
- RUN:
  - Issue of an instruction with id_branch_en=1 -> BR_WAIT.
  - br_resolved in RUN is ignored.
- BR_WAIT:
  - id_ready=0.
  - br_resolved & !br_taken -> RUN.
  - br_resolved & br_taken -> flush=1 in the same cycle, -> FLUSH.
- FLUSH:
  - id_ready=0 for one cycle, then -> RUN.
- id_ready = id_valid-independent: (state==RUN) & !load_use.

Stall counter:
- Increments on every cycle with id_valid & !id_ready.
- Holds at 2^CNT_W-1.

## Timing
Reset (async assert; synchronous-to-clk release is the system's job):
- state=RUN, S_EX and S_MEM invalid.
- ex_valid=0, fwd_a_sel=fwd_b_sel=00, stall_count=0, flush=0.
- id_ready=1 with empty shadows.

Issue and stall latency:
- Issue at edge N: ex_valid=1 and the fwd selects are valid from N+1 for one cycle.
- Load-use stall lasts exactly 1 cycle. The next cycle's compare sees the load in S_MEM, gives sel=10, and issues.

Branch latency:
- A branch issued at edge N enters BR_WAIT from N+1.
- Not-taken resolution in cycle K: next instruction can issue at edge K+1.
- Taken resolution in cycle K: flush=1 in cycle K, id_ready=0 in cycle K+1, issue at earliest edge K+2.

Simultaneous and boundary events:
- Branch that also hits load-use: the stall wins. The branch issues (and the FSM enters BR_WAIT) only when the stall clears.
- br_resolved in the same cycle the branch issues (RUN state): ignored.
- Reset mid-BR_WAIT: immediate return to RUN with shadows cleared. No flush pulse.
- id_valid=0: no issue, bubble shifts in, stall_count unchanged.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: issue add x5 (rd=5, wr=1), then add x6 using rs1=5.
  - Required: no stall; second instruction gets fwd_a_sel=01 with ex_valid=1.
  - Stimulus: a third instruction with rs2=5, rs2_en=1.
  - Required: fwd_b_sel=10.
- Load-use:
  - Stimulus: load rd=7, then an ALU op with rs2=7, rs2_en=1.
  - Required: id_ready=0 for exactly 1 cycle; ex_valid=0 bubble; then issue with fwd_b_sel=10; stall_count=1.
- x0 and disabled-operand rules:
  - Stimulus: load rd=0 followed by rs1=0.
  - Required: no stall, fwd_a_sel=00.
  - Stimulus: load rd=3 followed by rs2=3 with rs2_en=0.
  - Required: no stall.
- Branch resolution:
  - Stimulus: branch issued, then br_resolved=1, br_taken=0 three cycles later.
  - Required: id_ready=0 for 3 cycles; issue on the next edge.
  - Stimulus: repeat with br_taken=1.
  - Required: flush=1 in one cycle, one extra hold cycle, stall_count counts every held cycle.
- Reset during BR_WAIT:
  - Stimulus: assert rst mid-cycle.
  - Required: outputs go to reset values asynchronously, state RUN, id_ready=1 after release, no flush.
- Counter saturation:
  - Stimulus: CNT_W=4, hold id_valid=1 in BR_WAIT for 20 cycles.
  - Required: stall_count stops at 15.
